// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmit FSM states, keyboard command and
// response codes, and the odd-parity helper used on every PS/2 frame.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      WAIT_CLK,
      SEND,
      ACK,
      WAIT_IDLE,
      ERR
   } ps2_state_e;

   localparam logic [7:0] CMD_SET_LED  = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] RSP_ACK      = 8'hFA;
   localparam logic [7:0] BREAK_PREFIX = 8'hF0;

   // PS/2 parity bit makes the total count of ones over data+parity odd.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line conditioner: 2-flop synchronizer, stability filter and
// falling-edge detect. Shared by the host transmit and receive paths.
//   clk_i   system clock
//   rst_ni  async active-low reset (line assumed idle-high)
//   line_i  raw line level
//   filt_o  filtered level, changes only after FILTER_LEN equal samples
//   fall_o  one-cycle pulse in the cycle filt_o goes 1->0
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic line_i,
   output logic filt_o,
   output logic fall_o
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic          s1_q, s2_q, filt_q, fall_q;
   logic [CW-1:0] cnt_q;
   logic          accept;

   // cnt_q counts consecutive samples that disagree with the filtered level;
   // the FILTER_LEN-th disagreeing sample is accepted.
   assign accept = (s2_q != filt_q) && (cnt_q == CNT_LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q   <= 1'b1;
         s2_q   <= 1'b1;
         filt_q <= 1'b1;
         fall_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         s1_q   <= line_i;
         s2_q   <= s1_q;
         fall_q <= accept && !s2_q;
         if (s2_q == filt_q) begin
            cnt_q <= '0;
         end else if (accept) begin
            cnt_q  <= '0;
            filt_q <= s2_q;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign filt_o = filt_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter. Inhibits the clock, issues the start
// bit, shifts data/parity/stop on device falling edges, checks the device ack.
//   clk_i, rst_ni            clock, async active-low reset
//   tx_data_i/tx_valid_i     byte request, accepted on tx_valid_i && tx_ready_o
//   tx_ready_o               idle and both lines quiet
//   tx_done_o / tx_err_o     one-cycle completion / failure pulses
//   busy_o                   transfer in progress (receive path must ignore lines)
//   kbdclk_i / kbddat_i      raw line levels
//   kbdclk_oe_o/kbddat_oe_o  open-drain pull-low enables
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES     = 12000,
   parameter int START_HOLD_CYCLES  = 100,
   parameter int FIRST_EDGE_TIMEOUT = 1500000,
   parameter int XFER_TIMEOUT       = 200000,
   parameter int FILTER_LEN         = 8
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       tx_done_o,
   output logic       tx_err_o,
   output logic       busy_o,
   input  logic       kbdclk_i,
   input  logic       kbddat_i,
   output logic       kbdclk_oe_o,
   output logic       kbddat_oe_o
);

   localparam int MAX_A = (FIRST_EDGE_TIMEOUT > XFER_TIMEOUT) ? FIRST_EDGE_TIMEOUT : XFER_TIMEOUT;
   localparam int MAX_T = (MAX_A > INHIBIT_CYCLES) ? MAX_A : INHIBIT_CYCLES;
   localparam int CW    = $clog2(MAX_T + 1);
   localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] START_LAST = CW'(START_HOLD_CYCLES - 1);
   localparam logic [CW-1:0] FE_LAST    = CW'(FIRST_EDGE_TIMEOUT - 1);
   localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_TIMEOUT - 1);

   ps2_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_q, par_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic          dbit_q, dbit_d;

   logic clk_f, dev_fall, dat_f, dat_fall_unused;
   logic xfer_exp, keep_cnt;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk_i(clk_i), .rst_ni(rst_ni), .line_i(kbdclk_i), .filt_o(clk_f), .fall_o(dev_fall)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
      .clk_i(clk_i), .rst_ni(rst_ni), .line_i(kbddat_i), .filt_o(dat_f), .fall_o(dat_fall_unused)
   );

   assign xfer_exp = (cnt_q == XFER_LAST);

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      par_d    = par_q;
      bitcnt_d = bitcnt_q;
      dbit_d   = dbit_q;
      case (state_q)
         IDLE: begin
            if (tx_valid_i && tx_ready_o) begin
               shreg_d = tx_data_i;
               par_d   = odd_parity(tx_data_i);
               state_d = INHIBIT;
            end
         end
         INHIBIT:  if (cnt_q == INH_LAST) state_d = START;
         START:    if (cnt_q == START_LAST) state_d = WAIT_CLK;
         WAIT_CLK: begin
            if (dev_fall) begin
               dbit_d   = shreg_q[0];
               bitcnt_d = 4'd1;
               state_d  = SEND;
            end else if (cnt_q == FE_LAST) begin
               state_d = ERR;
            end
         end
         SEND: begin
            if (xfer_exp) begin
               state_d = ERR;
            end else if (bitcnt_q == 4'd10) begin
               state_d = ACK;
            end else if (dev_fall) begin
               if (bitcnt_q < 4'd8)       dbit_d = shreg_q[bitcnt_q[2:0]];
               else if (bitcnt_q == 4'd8) dbit_d = par_q;
               else                       dbit_d = 1'b1;   // stop bit
               bitcnt_d = bitcnt_q + 4'd1;
            end
         end
         ACK: begin
            if (xfer_exp)      state_d = ERR;
            else if (dev_fall) state_d = dat_f ? ERR : WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (xfer_exp)           state_d = ERR;
            else if (clk_f && dat_f) state_d = IDLE;
         end
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The counter restarts on every state entry, except that SEND -> ACK ->
   // WAIT_IDLE share one window so the transfer timeout spans all three.
   assign keep_cnt = (state_q inside {SEND, ACK}) && (state_d inside {ACK, WAIT_IDLE});

   always_comb begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
      if (state_d != state_q && !keep_cnt) cnt_d = '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shreg_q  <= '0;
         par_q    <= 1'b0;
         bitcnt_q <= '0;
         dbit_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shreg_q  <= shreg_d;
         par_q    <= par_d;
         bitcnt_q <= bitcnt_d;
         dbit_q   <= dbit_d;
      end
   end

   // Outputs decode straight from state so an async reset releases the lines
   // in the same instant.
   assign tx_ready_o  = (state_q == IDLE) && clk_f && dat_f;
   assign busy_o      = (state_q != IDLE);
   assign tx_done_o   = (state_q == WAIT_IDLE) && !xfer_exp && clk_f && dat_f;
   assign tx_err_o    = (state_q == ERR);
   assign kbdclk_oe_o = (state_q == INHIBIT) || (state_q == START);
   assign kbddat_oe_o = (state_q == START) || (state_q == WAIT_CLK) ||
                        ((state_q == SEND) && !dbit_q);

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH = 200, SH = 20, FET = 2000, XFER = 6000, FL = 4, H = 40;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_done, tx_err, busy, kbdclk_oe, kbddat_oe;
   logic       kbdclk, kbddat;
   logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0, dev_abort = 1'b0;
   int         dev_nfall = 0;
   int         checks = 0, failures = 0;

   always #5 clk = ~clk;

   assign kbdclk = ~(kbdclk_oe | dev_clk_low);
   assign kbddat = ~(kbddat_oe | dev_dat_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH), .START_HOLD_CYCLES(SH), .FIRST_EDGE_TIMEOUT(FET),
      .XFER_TIMEOUT(XFER), .FILTER_LEN(FL)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
      .tx_ready_o(tx_ready), .tx_done_o(tx_done), .tx_err_o(tx_err), .busy_o(busy),
      .kbdclk_i(kbdclk), .kbddat_i(kbddat), .kbdclk_oe_o(kbdclk_oe), .kbddat_oe_o(kbddat_oe)
   );

   // Reference frame as the device sees it on its sampling points:
   // start, D0..D7 LSB first, odd parity, stop.
   function automatic logic [10:0] frame(input logic [7:0] b);
      logic [10:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = b[i];
      f[9]  = (($countones(b) % 2) == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic dwait(input int n);
      for (int k = 0; k < n && !dev_abort; k++) @(negedge clk);
   endtask

   // Behavioural keyboard: measures inhibit/start hold, clocks 11 pulses,
   // samples on rising edges, optionally pulls data low for the ack.
   task automatic dev_run(input bit ack, output logic [10:0] bits, output int inh,
                          output int sth, output bit ok);
      int n;
      bits = '0; inh = 0; sth = 0; ok = 1'b0; n = 0;
      while (!kbdclk_oe && n < 5000 && !dev_abort) begin @(negedge clk); n++; end
      if (!kbdclk_oe) return;
      while (kbdclk_oe && !kbddat_oe && inh < 5000) begin inh++; @(negedge clk); end
      while (kbdclk_oe && kbddat_oe && sth < 5000) begin sth++; @(negedge clk); end
      if (!kbddat_oe) return;
      dwait(100);
      bits[0] = kbddat;
      for (int i = 1; i <= 10; i++) begin
         dev_clk_low = 1'b1; dev_nfall++;
         dwait(H);
         if (dev_abort) break;
         dev_clk_low = 1'b0;
         dwait(1);
         bits[i] = kbddat;
         dwait(H - 1);
         if (dev_abort) break;
      end
      if (!dev_abort) begin
         if (ack) dev_dat_low = 1'b1;
         dwait(H / 2);
         dev_clk_low = 1'b1; dev_nfall++;
         dwait(H);
         dev_clk_low = 1'b0;
         dwait(H / 2);
         dev_dat_low = 1'b0;
         dwait(2);
         ok = !dev_abort;
      end
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
   endtask

   task automatic mon(input int ncyc, output int nd, output int ne);
      nd = 0; ne = 0;
      repeat (ncyc) begin
         @(negedge clk);
         if (tx_done) nd++;
         if (tx_err) ne++;
      end
   endtask

   task automatic start_tx(input logic [7:0] b, output bit acc);
      int n;
      @(negedge clk);
      tx_data = b; tx_valid = 1'b1; n = 0;
      while (!tx_ready && n < 1000) begin @(negedge clk); n++; end
      acc = tx_ready;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (kbdclk_oe !== 1'b0) begin failures++; $display("FAIL reset_clk_oe got=%b exp=0", kbdclk_oe); end
      checks++; if (kbddat_oe !== 1'b0) begin failures++; $display("FAIL reset_dat_oe got=%b exp=0", kbddat_oe); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
      checks++; if ({tx_done, tx_err} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {tx_done, tx_err}); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
   endtask

   task automatic test_send(input logic [7:0] b);
      logic [10:0] bits; int inh, sth, nd, ne; bit ok, acc;
      start_tx(b, acc);
      fork
         dev_run(1'b1, bits, inh, sth, ok);
         mon(2000, nd, ne);
      join
      checks++; if (acc !== 1'b1) begin failures++; $display("FAIL send_accept b=%h got=%b exp=1", b, acc); end
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL send_dev_ok b=%h got=%b exp=1", b, ok); end
      checks++; if (inh !== INH) begin failures++; $display("FAIL send_inhibit b=%h got=%0d exp=%0d", b, inh, INH); end
      checks++; if (sth !== SH) begin failures++; $display("FAIL send_start_hold b=%h got=%0d exp=%0d", b, sth, SH); end
      checks++; if (bits !== frame(b)) begin failures++; $display("FAIL send_bits b=%h got=%b exp=%b", b, bits, frame(b)); end
      checks++; if (nd !== 1) begin failures++; $display("FAIL send_done_cnt b=%h got=%0d exp=1", b, nd); end
      checks++; if (ne !== 0) begin failures++; $display("FAIL send_err_cnt b=%h got=%0d exp=0", b, ne); end
      checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL send_ready_after b=%h got=%b exp=1", b, tx_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL send_busy_after b=%h got=%b exp=0", b, busy); end
   endtask

   task automatic test_no_clock();
      int n, nd, ne; bit acc, oe_bad;
      nd = 0; oe_bad = 1'b0;
      start_tx(CMD_ENABLE, acc);
      n = 0;
      while (!(kbdclk_oe == 1'b0 && kbddat_oe == 1'b1) && n < 1000) begin @(negedge clk); n++; end
      n = 0;
      while (!tx_err && n < FET + 100) begin
         @(negedge clk); n++;
         if (tx_done) nd++;
      end
      oe_bad = kbdclk_oe | kbddat_oe;
      checks++; if (n !== FET) begin failures++; $display("FAIL noclk_err_delay got=%0d exp=%0d", n, FET); end
      checks++; if (oe_bad !== 1'b0) begin failures++; $display("FAIL noclk_oe_released got=%b exp=0", oe_bad); end
      mon(100, n, ne);
      nd += n;
      checks++; if (nd !== 0) begin failures++; $display("FAIL noclk_done got=%0d exp=0", nd); end
      checks++; if (ne !== 0) begin failures++; $display("FAIL noclk_err_width extra=%0d exp=0", ne); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL noclk_idle got=%b exp=0", busy); end
   endtask

   task automatic test_no_ack();
      logic [10:0] bits; int inh, sth, nd, ne; bit ok, acc;
      start_tx(8'hA5, acc);
      fork
         dev_run(1'b0, bits, inh, sth, ok);
         mon(2000, nd, ne);
      join
      checks++; if (bits !== frame(8'hA5)) begin failures++; $display("FAIL noack_bits got=%b exp=%b", bits, frame(8'hA5)); end
      checks++; if (ne !== 1) begin failures++; $display("FAIL noack_err_cnt got=%0d exp=1", ne); end
      checks++; if (nd !== 0) begin failures++; $display("FAIL noack_done_cnt got=%0d exp=0", nd); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL noack_idle got=%b exp=0", busy); end
      test_send(CMD_RESET);
   endtask

   task automatic test_reset_mid();
      logic [10:0] bits; int inh, sth, nd, ne, n; bit ok, acc;
      logic [1:0] oe_rst;
      oe_rst = 2'b11;
      start_tx(CMD_SET_LED, acc);
      fork
         dev_run(1'b1, bits, inh, sth, ok);
         begin
            n = 0;
            while (dev_nfall < 5 && n < 5000) begin @(negedge clk); n++; end
            repeat (20) @(negedge clk);
            #2 rst_n = 1'b0;
            #1 oe_rst = {kbdclk_oe, kbddat_oe};
            dev_abort = 1'b1;
         end
      join
      checks++; if (oe_rst !== 2'b00) begin failures++; $display("FAIL rstmid_oe got=%b exp=00", oe_rst); end
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      dev_abort = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", tx_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      mon(300, nd, ne);
      checks++; if ({nd, ne} !== 64'd0) begin failures++; $display("FAIL rstmid_stale done=%0d err=%0d exp=0,0", nd, ne); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3; i++) test_send(8'($urandom_range(0, 255)));
   endtask

   task automatic test_back_to_back();
      logic [10:0] b1, b2; int inh, sth, nacc, nd, ne; bit ok1, ok2; logic pb;
      nacc = 0; nd = 0; ne = 0;
      fork
         begin
            dev_run(1'b1, b1, inh, sth, ok1);
            dev_run(1'b1, b2, inh, sth, ok2);
         end
         begin
            @(negedge clk);
            tx_data = 8'h00; tx_valid = 1'b1; pb = busy;
            for (int k = 0; k < 4000; k++) begin
               @(negedge clk);
               if (busy && !pb) begin
                  nacc++;
                  if (nacc == 1) tx_data = 8'hFF;
                  if (nacc == 2) tx_valid = 1'b0;
               end
               pb = busy;
               if (tx_done) nd++;
               if (tx_err) ne++;
            end
            tx_valid = 1'b0;
         end
      join
      checks++; if (nacc !== 2) begin failures++; $display("FAIL b2b_accepts got=%0d exp=2", nacc); end
      checks++; if (nd !== 2) begin failures++; $display("FAIL b2b_done got=%0d exp=2", nd); end
      checks++; if (ne !== 0) begin failures++; $display("FAIL b2b_err got=%0d exp=0", ne); end
      checks++; if ({ok1, ok2} !== 2'b11) begin failures++; $display("FAIL b2b_dev_ok got=%b exp=11", {ok1, ok2}); end
      checks++; if (b1 !== frame(8'h00)) begin failures++; $display("FAIL b2b_first got=%b exp=%b", b1, frame(8'h00)); end
      checks++; if (b1[9] !== 1'b1) begin failures++; $display("FAIL b2b_parity00 got=%b exp=1", b1[9]); end
      checks++; if (b2 !== frame(8'hFF)) begin failures++; $display("FAIL b2b_second got=%b exp=%b", b2, frame(8'hFF)); end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_send(CMD_SET_LED);
      test_send(CMD_ENABLE);
      test_no_clock();
      test_no_ack();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
